button_event_decoder: RTL

- Consumes the debounced button level from the debouncer stage and converts it into single-cycle event pulses: press, release, long-press, auto-repeat and double-click.
- Sits between the debouncer and the user-interface logic (menu/counter control), so downstream blocks never handle raw levels or timing.
- Same 100 MHz clock domain; all timing is in ms via an internal prescaler.

---
 rtl/button_event_decoder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle press, release, long-press,
// auto-repeat and double-click pulses, timed by an internal ms prescaler.
module button_event_decoder #(
  parameter int TICK_DIV  = 100000,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200,
  parameter int DCLICK_MS = 300
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press_p,
  output logic release_p,
  output logic long_p,
  output logic repeat_p,
  output logic dclick_p,
  output logic held
);

  localparam int MAX_LR = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
  localparam int MAX_MS = (MAX_LR > DCLICK_MS) ? MAX_LR : DCLICK_MS;
  localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MW     = $clog2(MAX_MS) + 1;

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    WAIT_SECOND,
    PRESSED2,
    LONG_HELD
  } state_t;

  state_t        state;
  logic          btn_q;
  logic [PW-1:0] pre;
  logic [MW-1:0] ms;

  logic rise, fall, tick;
  logic long_hit, rep_hit, dclick_hit;
  logic restart;

  assign rise = btn_in & ~btn_q;
  assign fall = ~btn_in & btn_q;
  assign tick = (pre == PW'(TICK_DIV - 1));

  // A hit is the last clock of the Nth ms, so the pulse lands N*TICK_DIV
  // clocks after the timer was cleared.
  assign long_hit   = tick && (ms == MW'(LONG_MS - 1));
  assign rep_hit    = tick && (ms == MW'(REPEAT_MS - 1));
  assign dclick_hit = tick && (ms == MW'(DCLICK_MS - 1));

  // NOTE: every variable assigned in always_comb gets a default first so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    restart = 1'b0;
    case (state)
      IDLE:               restart = rise;
      PRESSED, PRESSED2:  restart = fall | long_hit;
      LONG_HELD:          restart = fall | rep_hit;
      WAIT_SECOND:        restart = rise | dclick_hit;
      default:            restart = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the value from before this clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      btn_q     <= 1'b0;
      pre       <= '0;
      ms        <= '0;
      press_p   <= 1'b0;
      release_p <= 1'b0;
      long_p    <= 1'b0;
      repeat_p  <= 1'b0;
      dclick_p  <= 1'b0;
      held      <= 1'b0;
    end else begin
      btn_q     <= btn_in;
      press_p   <= 1'b0;
      release_p <= 1'b0;
      long_p    <= 1'b0;
      repeat_p  <= 1'b0;
      dclick_p  <= 1'b0;

      // Timer rests at zero in IDLE so it can never wrap there.
      if (state == IDLE || restart) begin
        pre <= '0;
        ms  <= '0;
      end else if (tick) begin
        pre <= '0;
        ms  <= ms + MW'(1);
      end else begin
        pre <= pre + PW'(1);
      end

      // Edges are tested before expiries so a coincident edge always wins.
      case (state)
        IDLE: begin
          if (rise) begin
            press_p <= 1'b1;
            held    <= 1'b1;
            state   <= PRESSED;
          end
        end
        PRESSED, PRESSED2: begin
          if (fall) begin
            release_p <= 1'b1;
            held      <= 1'b0;
            state     <= (state == PRESSED) ? WAIT_SECOND : IDLE;
          end else if (long_hit) begin
            long_p <= 1'b1;
            state  <= LONG_HELD;
          end
        end
        LONG_HELD: begin
          if (fall) begin
            release_p <= 1'b1;
            held      <= 1'b0;
            state     <= IDLE;
          end else if (rep_hit) begin
            repeat_p <= 1'b1;
          end
        end
        WAIT_SECOND: begin
          if (rise) begin
            press_p  <= 1'b1;
            dclick_p <= 1'b1;
            held     <= 1'b1;
            state    <= PRESSED2;
          end else if (dclick_hit) begin
            state <= IDLE;
          end
        end
        default: begin
          held  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
